// File: rtl/placar_ctrl.sv
// Scoreboard sequencing controller: button conditioning, operand hand-off to
// an external adder/subtractor, saturated 0..99 score commit, overflow flag,
// ch preset-to-99 and the two-digit display scan select.
module placar_ctrl #(
   parameter logic [15:0] DB_CYCLES   = 16'd50000,
   parameter int          ADD_LAT     = 2,
   parameter logic [15:0] REFRESH_DIV = 16'd25000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] btn,
   input  logic       sinal,
   input  logic       ch,
   input  logic [6:0] s,
   input  logic       cout,
   output logic [6:0] teste,
   output logic [6:0] pontos,
   output logic       sinal_op,
   output logic [6:0] score,
   output logic       busy,
   output logic       done,
   output logic       alerta,
   output logic [1:0] sclk
);

   localparam int WW = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_LOAD   = 2'd1,
      S_WAIT   = 2'd2,
      S_COMMIT = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [WW-1:0]   wait_cnt_q, wait_cnt_d;
   logic [6:0]      score_q, score_d;
   logic [6:0]      pontos_q, pontos_d;
   logic            sinal_op_q, sinal_op_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            alerta_q, alerta_d;

   logic [2:0]      sync1_q, sync2_q;
   logic [2:0]      btn_lvl;
   logic [2:0]      db_lvl;
   logic [2:0]      press_evt;
   logic            evt_any;
   logic [1:0]      evt_idx;

   logic [15:0]     ref_cnt_q;
   logic [1:0]      sclk_q;

   // Two-stage synchronizer; buttons idle high, so reset to released
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= 3'b111;
         sync2_q <= 3'b111;
      end else begin
         sync1_q <= btn;
         sync2_q <= sync1_q;
      end
   end

   assign btn_lvl = ~sync2_q;

   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_db
         logic [15:0] db_cnt_q;
         logic        db_lvl_q;
         logic        db_prev_q;

         // Accept a new level only after DB_CYCLES consecutive disagreeing samples
         always_ff @(posedge clk) begin
            if (rst) begin
               db_cnt_q  <= 16'd0;
               db_lvl_q  <= 1'b0;
               db_prev_q <= 1'b0;
            end else begin
               db_prev_q <= db_lvl_q;
               if (btn_lvl[gi] != db_lvl_q) begin
                  if (db_cnt_q == DB_CYCLES - 16'd1) begin
                     db_lvl_q <= btn_lvl[gi];
                     db_cnt_q <= 16'd0;
                  end else begin
                     db_cnt_q <= db_cnt_q + 16'd1;
                  end
               end else begin
                  db_cnt_q <= 16'd0;
               end
            end
         end

         assign db_lvl[gi]    = db_lvl_q;
         assign press_evt[gi] = db_lvl_q & ~db_prev_q;
      end
   endgenerate

   // Same-cycle presses: highest point value wins, the rest are dropped
   always_comb begin
      evt_any = |press_evt;
      if (press_evt[2])      evt_idx = 2'd2;
      else if (press_evt[1]) evt_idx = 2'd1;
      else                   evt_idx = 2'd0;
   end

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         wait_cnt_q <= '0;
         score_q    <= 7'd0;
         pontos_q   <= 7'd0;
         sinal_op_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         alerta_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         score_q    <= score_d;
         pontos_q   <= pontos_d;
         sinal_op_q <= sinal_op_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         alerta_q   <= alerta_d;
      end
   end

   // Next-state logic; ch preempts a button event in IDLE
   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      case (state_q)
         S_IDLE: begin
            if (!ch && evt_any) state_d = S_LOAD;
         end
         S_LOAD: begin
            state_d    = S_WAIT;
            wait_cnt_d = WW'(ADD_LAT - 1);
         end
         S_WAIT: begin
            if (wait_cnt_q == '0) state_d = S_COMMIT;
            else                  wait_cnt_d = wait_cnt_q - 1'b1;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Output/datapath next values: operand latch, preset and result commit
   always_comb begin
      score_d    = score_q;
      pontos_d   = pontos_q;
      sinal_op_d = sinal_op_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      alerta_d   = alerta_q;
      case (state_q)
         S_IDLE: begin
            pontos_d = 7'd0;
            if (ch) begin
               score_d = 7'd99;
               done_d  = 1'b1;
            end else if (evt_any) begin
               pontos_d   = 7'(evt_idx) + 7'd1;
               sinal_op_d = sinal;
               busy_d     = 1'b1;
            end
         end
         S_COMMIT: begin
            busy_d   = 1'b0;
            done_d   = 1'b1;
            pontos_d = 7'd0;
            if (!sinal_op_q) begin
               if (cout || (s > 7'd99)) begin
                  score_d  = 7'd99;
                  alerta_d = 1'b1;
               end else begin
                  score_d  = s;
                  alerta_d = 1'b0;
               end
            end else begin
               // Underflow judged on the operands, the adder's borrow is ignored
               score_d  = (score_q < pontos_q) ? 7'd0 : s;
               alerta_d = 1'b0;
            end
         end
         default: begin
         end
      endcase
   end

   // Free-running digit scan, one-hot and independent of the FSM
   always_ff @(posedge clk) begin
      if (rst) begin
         ref_cnt_q <= 16'd0;
         sclk_q    <= 2'b01;
      end else if (ref_cnt_q == REFRESH_DIV - 16'd1) begin
         ref_cnt_q <= 16'd0;
         sclk_q    <= {sclk_q[0], sclk_q[1]};
      end else begin
         ref_cnt_q <= ref_cnt_q + 16'd1;
      end
   end

   // Score is unchanged while an operation is in flight, so it doubles as operand A
   assign teste    = score_q;
   assign pontos   = pontos_q;
   assign sinal_op = sinal_op_q;
   assign score    = score_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign alerta   = alerta_q;
   assign sclk     = sclk_q;

   // Debounced levels only feed the edge detectors
   logic unused_db;
   assign unused_db = ^db_lvl;

endmodule

// File: tb/tb_placar_ctrl.sv
// Scoreboard bench for placar_ctrl: expected score/alerta pushed at stimulus
// time, popped and compared by a monitor on every done pulse.
module tb_placar_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] btn;
   logic       sinal;
   logic       ch;
   logic [6:0] s;
   logic       cout;
   logic [6:0] teste;
   logic [6:0] pontos;
   logic       sinal_op;
   logic [6:0] score;
   logic       busy;
   logic       done;
   logic       alerta;
   logic [1:0] sclk;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   logic [7:0] exp_q[$];
   int         model_score  = 0;
   int         model_alerta = 0;

   logic [7:0] add_p1, add_p2;
   int         m_cnt  = 0;
   logic [1:0] m_sclk = 2'b01;

   placar_ctrl #(
      .DB_CYCLES  (16'd4),
      .ADD_LAT    (2),
      .REFRESH_DIV(16'd8)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .btn     (btn),
      .sinal   (sinal),
      .ch      (ch),
      .s       (s),
      .cout    (cout),
      .teste   (teste),
      .pontos  (pontos),
      .sinal_op(sinal_op),
      .score   (score),
      .busy    (busy),
      .done    (done),
      .alerta  (alerta),
      .sclk    (sclk)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // External adder/subtractor model with two cycles of latency
   always @(posedge clk) begin
      add_p1 <= sinal_op ? ({1'b0, teste} - {1'b0, pontos}) : ({1'b0, teste} + {1'b0, pontos});
      add_p2 <= add_p1;
   end
   assign s    = add_p2[6:0];
   assign cout = add_p2[7];

   // Expected display scan
   always @(posedge clk) begin
      if (rst) begin
         m_cnt  <= 0;
         m_sclk <= 2'b01;
      end else if (m_cnt == 7) begin
         m_cnt  <= 0;
         m_sclk <= {m_sclk[0], m_sclk[1]};
      end else begin
         m_cnt <= m_cnt + 1;
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every done pulse must match the oldest expected update
   always @(negedge clk) begin
      chk("sclk", int'(sclk), int'(m_sclk));
      if (done) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_done", int'(done), 0);
         end else begin
            logic [7:0] e;
            e = exp_q.pop_front();
            chk("score", int'(score), int'(e[6:0]));
            chk("alerta", int'(alerta), int'(e[7]));
            chk("busy_at_done", int'(busy), 0);
            $display("update: score=%0d alerta=%0d (expected %0d/%0d)", score, alerta, e[6:0], e[7]);
         end
      end
   end

   task automatic go(input int k);
      while (cyc < k) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic nego(input int k);
      forever begin
         @(negedge clk);
         if (cyc >= k) break;
      end
   endtask

   task automatic push_op(input int pts, input bit sub);
      if (sub) begin
         model_score  = (model_score < pts) ? 0 : model_score - pts;
         model_alerta = 0;
      end else if (model_score + pts > 99) begin
         model_score  = 99;
         model_alerta = 1;
      end else begin
         model_score  = model_score + pts;
         model_alerta = 0;
      end
      exp_q.push_back({model_alerta[0], model_score[6:0]});
   endtask

   task automatic push_ch();
      model_score = 99;
      exp_q.push_back({model_alerta[0], 7'd99});
   endtask

   task automatic model_reset();
      model_score  = 0;
      model_alerta = 0;
      exp_q.delete();
   endtask

   // Standard press: hold one button low, release, let everything settle
   task automatic press(input int idx, input bit sub, input int nlow);
      int c0;
      c0 = cyc;
      btn[idx] = 1'b0;
      sinal    = sub;
      push_op(idx + 1, sub);
      go(c0 + nlow);
      btn[idx] = 1'b1;
      go(c0 + 20);
   endtask

   initial begin
      int c0;
      rst   = 1'b1;
      btn   = 3'b111;
      sinal = 1'b0;
      ch    = 1'b0;

      // Reset state
      go(3);
      rst = 1'b0;
      nego(3);
      chk("rst_score", int'(score), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_alerta", int'(alerta), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_pontos", int'(pontos), 0);
      chk("rst_sclk", int'(sclk), 1);

      // Reset held 3 cycles in WAIT discards the pending add
      go(cyc + 1);
      c0 = cyc;
      btn[0] = 1'b0;
      go(c0 + 6);
      btn[0] = 1'b1;
      go(c0 + 8);
      rst = 1'b1;
      nego(c0 + 9);
      chk("midwait_score", int'(score), 0);
      chk("midwait_busy", int'(busy), 0);
      chk("midwait_alerta", int'(alerta), 0);
      chk("midwait_sclk", int'(sclk), 1);
      go(c0 + 11);
      rst = 1'b0;
      model_reset();
      go(c0 + 30);
      nego(c0 + 30);
      chk("midwait_lost", int'(score), 0);
      go(cyc + 1);

      // Climb to 40: 13 x 3 points, then 1 point
      for (int i = 0; i < 13; i++) press(2, 1'b0, 6);
      press(0, 1'b0, 6);

      // 2-point add from 40 with exact latency and stable operand
      c0 = cyc;
      btn[1] = 1'b0;
      sinal  = 1'b0;
      push_op(2, 1'b0);
      go(c0 + 6);
      btn[1] = 1'b1;
      for (int k = 7; k <= 10; k++) begin
         nego(c0 + k);
         chk("lat_pontos", int'(pontos), 2);
         chk("lat_busy", int'(busy), 1);
         chk("lat_teste", int'(teste), 40);
      end
      chk("lat_no_early_done", int'(done), 0);
      nego(c0 + 11);
      chk("lat_done", int'(done), 1);
      chk("lat_score", int'(score), 42);
      go(c0 + 20);

      // 3-cycle glitch on btn[0] is not an event
      c0 = cyc;
      btn[0] = 1'b0;
      go(c0 + 3);
      btn[0] = 1'b1;
      go(c0 + 20);
      nego(c0 + 20);
      chk("glitch_score", int'(score), 42);
      go(cyc + 1);

      // Preset to 99, down to 98, saturating add, then clear alerta
      c0 = cyc;
      ch = 1'b1;
      push_ch();
      go(c0 + 1);
      ch = 1'b0;
      go(c0 + 5);
      press(0, 1'b1, 6);
      press(2, 1'b0, 6);
      press(0, 1'b1, 6);

      // Subtract underflow clamps to 0
      rst = 1'b1;
      go(cyc + 2);
      rst = 1'b0;
      model_reset();
      go(cyc + 2);
      press(0, 1'b0, 6);
      press(2, 1'b1, 6);

      // btn[0]+btn[2] together, then btn[1] arriving while busy
      c0 = cyc;
      btn   = 3'b010;
      sinal = 1'b0;
      push_op(3, 1'b0);
      go(c0 + 3);
      btn = 3'b000;
      go(c0 + 6);
      btn = 3'b101;
      nego(c0 + 7);
      chk("prio_pontos", int'(pontos), 3);
      go(c0 + 9);
      btn = 3'b111;
      go(c0 + 30);
      nego(c0 + 30);
      chk("prio_score_once", int'(score), 3);
      go(cyc + 1);

      // ch beats a same-cycle btn[1] event
      c0 = cyc;
      btn[1] = 1'b0;
      push_ch();
      go(c0 + 6);
      btn[1] = 1'b1;
      ch     = 1'b1;
      go(c0 + 7);
      ch = 1'b0;
      nego(c0 + 7);
      chk("ch_score", int'(score), 99);
      chk("ch_busy", int'(busy), 0);
      nego(c0 + 8);
      chk("ch_no_op_busy", int'(busy), 0);
      chk("ch_no_op_pontos", int'(pontos), 0);
      go(c0 + 20);

      // ch during WAIT: subtract commits first, then preset applies
      c0 = cyc;
      btn[0] = 1'b0;
      sinal  = 1'b1;
      push_op(1, 1'b1);
      push_ch();
      go(c0 + 6);
      btn[0] = 1'b1;
      go(c0 + 8);
      ch = 1'b1;
      nego(c0 + 11);
      chk("chwait_commit", int'(score), 98);
      go(c0 + 12);
      ch = 1'b0;
      go(c0 + 25);

      nego(cyc);
      chk("pending_updates", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/placar_ctrl.md
Name: placar_ctrl

Overview:
- Sequencing controller for the scoreboard datapath (7-bit adder/subtractor -> binary-to-BCD -> two-digit 7-segment display).
- Debounces the three point buttons and selects add or subtract from sinal.
- Presents operands to the external adder/subtractor, waits for its result, then commits a saturated 0..99 score.
- Owns alerta, the ch preset-to-99 and the two-digit display scan select.

Parameters:
- DB_CYCLES, 16'd50000, consecutive stable cycles required before a synchronized button level is accepted.
- ADD_LAT, 2, cycles between operand presentation and s/cout valid (minimum 1).
- REFRESH_DIV, 16'd25000, cycles per display digit before sclk toggles.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- btn  in  3  raw board buttons, active-low; btn[0]=1 pt, btn[1]=2 pts, btn[2]=3 pts
- sinal  in  1  operation select: 0 add, 1 subtract; sampled at event acceptance
- ch  in  1  level; 1 forces the score to 99
- s  in  7  adder/subtractor result
- cout  in  1  adder/subtractor carry out
- teste  out  7  operand A to adder (current score)
- pontos  out  7  operand B to adder (point value)
- sinal_op  out  1  latched operation to adder
- score  out  7  committed score, binary, 0..99
- busy  out  1  operation in flight
- done  out  1  one-cycle pulse on score update
- alerta  out  1  sticky overflow flag
- sclk  out  2  one-hot digit enable, [0]=units, [1]=tens

Behaviour:
- Reset (any state, including mid-operation): FSM=IDLE, score=0, teste=0, pontos=0, sinal_op=0, busy=0, done=0, alerta=0, sclk=2'b01, debounce counters=0, debounced levels=released. Any in-flight operation is discarded.
- Input conditioning, per button:
  - 2-FF synchronizer, then inversion.
  - A debounced level changes only after the synchronized level differs from it for DB_CYCLES consecutive cycles; any bounce restarts the count.
  - A press event is a registered released->pressed transition of the debounced level, one cycle wide. Release produces no event.
- Event selection:
  - Same-cycle events resolve by priority btn[2] > btn[1] > btn[0]; the losers are dropped.
  - Events arriving while FSM != IDLE are dropped, not queued.
- FSM states: IDLE, LOAD, WAIT, COMMIT.
  - IDLE:
    - Drives teste=score and pontos=0.
    - If ch=1, score<=99 next cycle; alerta unchanged; done pulses; events that cycle are ignored. ch has priority over button events.
    - Else, on an event, latch pontos=index+1 and sinal_op=sinal, then go to LOAD.
  - LOAD: teste=score; busy=1; go to WAIT; wait counter=ADD_LAT-1.
  - WAIT: decrement the counter; go to COMMIT when it reaches 0. teste, pontos and sinal_op stay stable from LOAD through COMMIT.
  - COMMIT: capture the result, then return to IDLE.
- COMMIT rules:
  - Add: if cout=1 or s>99, score<=99 and alerta<=1; else score<=s and alerta<=0.
  - Subtract: underflow is decided by the internal compare teste<pontos, not by s/cout. On underflow score<=0; else score<=s. alerta<=0 in both cases.
- Latency: with the event registered in cycle T, LOAD=T+1, WAIT=T+2..T+1+ADD_LAT, COMMIT=T+2+ADD_LAT. The new score and done=1 are visible at T+3+ADD_LAT; busy falls in that same cycle.
- ch held during busy: ignored until IDLE, then applied.
- Display scan: free-running counter independent of the FSM. sclk toggles 01<->10 every REFRESH_DIV cycles and is never 00 or 11.

Test Plan (DB_CYCLES=4, ADD_LAT=2, REFRESH_DIV=8, adder model s=A±B with ADD_LAT delay):
- rst held 3 cycles mid-WAIT -> score=0, busy=0, alerta=0, sclk=01 on the cycle after rst; no done pulse; the pending add is lost.
- btn[1] low for 6 cycles, sinal=0, score=40 -> pontos=2 through COMMIT; score=42 and done pulse exactly 5 cycles after the event cycle; a 3-cycle glitch on btn[0] produces no event.
- score=98, btn[2] add -> score=99, alerta=1. Then btn[0] subtract -> score=98, alerta=0.
- score=1, btn[2] subtract -> score=0 (no wrap to 126), alerta=0.
- btn[0] and btn[2] pressed in the same cycle -> one operation with pontos=3. A second press during busy -> ignored; score changes once.
- ch=1 in IDLE with a simultaneous btn[1] event -> score=99 next cycle, no adder operation. ch asserted during WAIT -> current op commits, then score=99. sclk toggles every 8 cycles throughout.
